// File: rtl/display_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_sequencer
// Description : Scan stage for a two-digit hex display. It divides the system
//               clock into display phases and produces the 3-bit phase code
//               for the character generator. It drives the active-low digit
//               anodes and latches a tear-free snapshot of the display value
//               once per frame (8 phases).
//
//               Phase codes:
//                 000..010 : high nibble (x00/x10 are guard phases)
//                 100..110 : low nibble
//                 011/111  : blank
//               Only x01 actually lights a digit.
//
// Ports       : clock      - system clock, rising edge
//               reset      - asynchronous, active-high
//               enable     - 1 = scan, 0 = hold (anodes blanked)
//               data_in    - live 8-bit value to display
//               counter    - phase code to the character generator
//               anode      - digit enables, active-low
//               data_out   - frame-stable snapshot of data_in
//               frame_tick - one-cycle pulse at each frame start
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_sequencer #(
  parameter int DIV      = 50000,  // clock cycles per phase (2..2^CW-1)
  parameter int CW       = 16,     // prescaler width
  parameter int HI_DIGIT = 1,      // anode index that shows the high nibble
  parameter int LO_DIGIT = 0       // anode index that shows the low nibble
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in,
  output logic [2:0] counter,
  output logic [3:0] anode,
  output logic [7:0] data_out,
  output logic       frame_tick
);

  // Parameter sanity checks, evaluated at elaboration.
  if (DIV < 2 || DIV > (2 ** CW) - 1) begin : g_bad_div
    $error("display_scan_sequencer: DIV out of range for CW");
  end
  if (HI_DIGIT < 0 || HI_DIGIT > 3 || LO_DIGIT < 0 || LO_DIGIT > 3 ||
      HI_DIGIT == LO_DIGIT) begin : g_bad_digit
    $error("display_scan_sequencer: illegal HI_DIGIT/LO_DIGIT");
  end

  localparam logic [CW-1:0] c_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] c_ONE    = CW'(1);
  localparam logic [1:0]    c_HI_IDX = 2'(HI_DIGIT);
  localparam logic [1:0]    c_LO_IDX = 2'(LO_DIGIT);

  logic [CW-1:0] r_prescaler;
  logic [2:0]    r_counter;
  logic [3:0]    r_anode;
  logic [7:0]    r_data_out;
  logic          r_frame_tick;

  logic          w_tick;
  logic [2:0]    w_cnt_next;
  logic [3:0]    w_anode_next;

  // The tick is gated by enable, so dropping enable on a would-be tick edge
  // suppresses the phase advance.
  assign w_tick     = enable && (r_prescaler == c_LAST);
  assign w_cnt_next = w_tick ? (r_counter + 3'd1) : r_counter;

  // Anode is decoded from the counter value that will be loaded on this edge,
  // so anode and counter change together. The guard phases on either side of
  // each lit phase cover the character generator's register latency.
  always_comb begin
    w_anode_next = 4'b1111;
    if (w_cnt_next == 3'b001) begin
      w_anode_next[c_HI_IDX] = 1'b0;
    end else if (w_cnt_next == 3'b101) begin
      w_anode_next[c_LO_IDX] = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prescaler  <= '0;
      r_counter    <= 3'b000;
      r_anode      <= 4'b1111;
      r_data_out   <= 8'h00;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= 1'b0;
      if (enable) begin
        r_prescaler <= w_tick ? '0 : (r_prescaler + c_ONE);
        r_counter   <= w_cnt_next;
        r_anode     <= w_anode_next;
        // Snapshot only on the 111 -> 000 wrap, so the value shown stays
        // constant for a whole frame.
        if (w_tick && (r_counter == 3'b111)) begin
          r_data_out   <= data_in;
          r_frame_tick <= 1'b1;
        end
      end else begin
        // Hold: prescaler, counter and snapshot keep their values, digits off.
        r_anode <= 4'b1111;
      end
    end
  end

  assign counter    = r_counter;
  assign anode      = r_anode;
  assign data_out   = r_data_out;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_sequencer
// Description : Self-checking bench. Instance 0 uses DIV=4, HI=1, LO=0 and
//               instance 1 uses DIV=2, HI=3, LO=2. Both instances share their
//               inputs. Expected outputs come from a reference model that
//               counts enabled edges since reset, a directed vector table,
//               and hand-written corner-case sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_sequencer;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] data_in;

  logic [2:0] cnt_o  [2];
  logic [3:0] an_o   [2];
  logic [7:0] dout_o [2];
  logic       ft_o   [2];

  int n_tests = 0;
  int n_fail  = 0;

  display_scan_sequencer #(.DIV(4), .CW(16), .HI_DIGIT(1), .LO_DIGIT(0)) u_dut0 (
    .clock      (clk),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .counter    (cnt_o[0]),
    .anode      (an_o[0]),
    .data_out   (dout_o[0]),
    .frame_tick (ft_o[0])
  );

  display_scan_sequencer #(.DIV(2), .CW(16), .HI_DIGIT(3), .LO_DIGIT(2)) u_dut1 (
    .clock      (clk),
    .reset      (reset),
    .enable     (enable),
    .data_in    (data_in),
    .counter    (cnt_o[1]),
    .anode      (an_o[1]),
    .data_out   (dout_o[1]),
    .frame_tick (ft_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The model counts enabled edges since reset. The phase is (E/DIV) mod 8,
  // and a frame starts whenever E is a nonzero multiple of 8*DIV.
  int         m_div [2] = '{4, 2};
  int         m_hi  [2] = '{1, 3};
  int         m_lo  [2] = '{0, 2};
  int         m_e   [2];
  bit         m_en  [2];
  logic [7:0] m_snap[2];
  bit         m_ft  [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_e[i] = 0; m_en[i] = 0; m_snap[i] = 8'h00; m_ft[i] = 0;
    end
  endfunction

  function automatic void model_edge(input logic en, input logic [7:0] din);
    for (int i = 0; i < 2; i++) begin
      m_en[i] = en;
      m_ft[i] = 0;
      if (en) begin
        m_e[i]++;
        if (m_e[i] % (8 * m_div[i]) == 0) begin
          m_snap[i] = din;
          m_ft[i]   = 1;
        end
      end
    end
  endfunction

  function automatic logic [2:0] model_cnt(input int i);
    return 3'((m_e[i] / m_div[i]) % 8);
  endfunction

  function automatic logic [3:0] model_an(input int i);
    int ph;
    ph = (m_e[i] / m_div[i]) % 8;
    if (!m_en[i]) return 4'b1111;
    if (ph == 1) return ~(4'b0001 << m_hi[i]);
    if (ph == 5) return ~(4'b0001 << m_lo[i]);
    return 4'b1111;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s u%0d counter", tag, i), {5'd0, cnt_o[i]}, {5'd0, model_cnt(i)});
      chk($sformatf("%s u%0d anode", tag, i), {4'd0, an_o[i]}, {4'd0, model_an(i)});
      chk($sformatf("%s u%0d data_out", tag, i), dout_o[i], m_snap[i]);
      chk($sformatf("%s u%0d frame_tick", tag, i), {7'd0, ft_o[i]}, {7'd0, m_ft[i]});
    end
  endtask

  // Called right after a negedge: drive inputs, take one edge, check at negedge.
  task automatic step(input logic en, input logic [7:0] din, input string tag);
    enable  = en;
    data_in = din;
    @(posedge clk);
    model_edge(en, din);
    @(negedge clk);
    check_model(tag);
  endtask

  // Asynchronous reset asserted between edges; the outputs must clear at once.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s u%0d rst counter", tag, i), {5'd0, cnt_o[i]}, 8'h00);
      chk($sformatf("%s u%0d rst anode", tag, i), {4'd0, an_o[i]}, 8'h0F);
      chk($sformatf("%s u%0d rst data_out", tag, i), dout_o[i], 8'h00);
      chk($sformatf("%s u%0d rst frame_tick", tag, i), {7'd0, ft_o[i]}, 8'h00);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_model({tag, " post"});
  endtask

  // ---------------- directed vector table (instance 0, DIV=4) ----------------
  typedef struct {
    logic       en;
    logic [7:0] din;
    int         cycles;
    logic [2:0] cnt;
    logic [3:0] an;
    logic       ft;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{1'b1, 8'hA5,  3, 3'd0, 4'hF, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'hA5,  1, 3'd1, 4'hD, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 8'hA5,  3, 3'd1, 4'hD, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 8'hA5,  1, 3'd2, 4'hF, 1'b0, 8'h00};
    tbl[4]  = '{1'b1, 8'hA5,  8, 3'd4, 4'hF, 1'b0, 8'h00};
    tbl[5]  = '{1'b1, 8'hA5,  4, 3'd5, 4'hE, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 8'hA5,  3, 3'd5, 4'hE, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 8'hA5,  1, 3'd6, 4'hF, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 8'hA5,  4, 3'd7, 4'hF, 1'b0, 8'h00};
    tbl[9]  = '{1'b1, 8'hA5,  3, 3'd7, 4'hF, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 8'hA5,  1, 3'd0, 4'hF, 1'b1, 8'hA5};
    tbl[11] = '{1'b1, 8'hA5,  8, 3'd2, 4'hF, 1'b0, 8'hA5};
    tbl[12] = '{1'b1, 8'h3C, 23, 3'd7, 4'hF, 1'b0, 8'hA5};
    tbl[13] = '{1'b1, 8'h3C,  1, 3'd0, 4'hF, 1'b1, 8'h3C};
    tbl[14] = '{1'b1, 8'h3C,  1, 3'd0, 4'hF, 1'b0, 8'h3C};
  end

  // ---------------- main sequence ----------------
  int ft_edges[$];

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    data_in = 8'h00;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_model("init");

    // Table: first phases, full frame, and a mid-frame data change.
    async_reset("tbl");
    for (int k = 0; k < 15; k++) begin
      for (int c = 0; c < tbl[k].cycles; c++) step(tbl[k].en, tbl[k].din, "tbl");
      chk($sformatf("tbl[%0d] counter", k), {5'd0, cnt_o[0]}, {5'd0, tbl[k].cnt});
      chk($sformatf("tbl[%0d] anode", k), {4'd0, an_o[0]}, {4'd0, tbl[k].an});
      chk($sformatf("tbl[%0d] frame_tick", k), {7'd0, ft_o[0]}, {7'd0, tbl[k].ft});
      chk($sformatf("tbl[%0d] data_out", k), dout_o[0], tbl[k].dout);
    end

    // Hold in phase 001 with prescaler=2, then resume.
    async_reset("hold");
    for (int c = 0; c < 6; c++) step(1'b1, 8'h11, "hold");
    chk("hold pre counter", {5'd0, cnt_o[0]}, 8'h01);
    chk("hold pre anode", {4'd0, an_o[0]}, 8'h0D);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 8'h11, "hold");
      chk("hold counter", {5'd0, cnt_o[0]}, 8'h01);
      chk("hold anode", {4'd0, an_o[0]}, 8'h0F);
    end
    step(1'b1, 8'h11, "hold");
    chk("resume1 counter", {5'd0, cnt_o[0]}, 8'h01);
    chk("resume1 anode", {4'd0, an_o[0]}, 8'h0D);
    step(1'b1, 8'h11, "hold");
    chk("resume2 counter", {5'd0, cnt_o[0]}, 8'h02);
    chk("resume2 anode", {4'd0, an_o[0]}, 8'h0F);

    // Asynchronous reset in phase 101 of the second frame, then restart timing.
    async_reset("arst");
    for (int c = 0; c < 54; c++) step(1'b1, 8'hA5, "arst");
    chk("arst pre anode", {4'd0, an_o[0]}, 8'h0E);
    chk("arst pre data_out", dout_o[0], 8'hA5);
    async_reset("arst");
    for (int c = 0; c < 3; c++) step(1'b1, 8'h5A, "arst");
    chk("arst e3 counter", {5'd0, cnt_o[0]}, 8'h00);
    step(1'b1, 8'h5A, "arst");
    chk("arst e4 counter", {5'd0, cnt_o[0]}, 8'h01);
    chk("arst e4 anode", {4'd0, an_o[0]}, 8'h0D);

    // Instance 1 (DIV=2, HI=3, LO=2): digit mapping and frame period.
    async_reset("div2");
    for (int c = 1; c <= 40; c++) begin
      step(1'b1, 8'(c), "div2");
      if (c == 2)  chk("div2 phase1 anode", {4'd0, an_o[1]}, 8'h07);
      if (c == 10) chk("div2 phase5 anode", {4'd0, an_o[1]}, 8'h0B);
      if (ft_o[1]) ft_edges.push_back(c);
    end
    chk("div2 tick count", 8'(ft_edges.size()), 8'd2);
    if (ft_edges.size() == 2) begin
      chk("div2 first tick", 8'(ft_edges[0]), 8'd16);
      chk("div2 period", 8'(ft_edges[1] - ft_edges[0]), 8'd16);
    end

    // Randomized stimulus against the model, with occasional resets.
    async_reset("rand");
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset("rand");
      step(($urandom_range(0, 9) != 0), 8'($urandom), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_scan_sequencer.md
Name: display_scan_sequencer

Overview:
Upstream scan stage for the two-digit hex display path. It divides the system clock into display phases and drives the 3-bit phase code consumed by the character generator. It also drives the active-low digit anodes and captures a tear-free snapshot of the 8-bit display value once per frame. Phase codes: 000–010 select the high nibble, 100–110 select the low nibble, and 011/111 are blank.

Parameters:
DIV, 50000, clock cycles per phase (legal range 2..2^CW-1)
CW, 16, prescaler counter width
HI_DIGIT, 1, anode index that shows the high nibble (0..3)
LO_DIGIT, 0, anode index that shows the low nibble (0..3, distinct from HI_DIGIT)

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high
enable  in  1  scan run/hold
data_in  in  8  live value to display
counter  out  3  phase code to the character generator
anode  out  4  digit enables, active-low
data_out  out  8  frame-stable snapshot of data_in, fed to the character generator
frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset (asynchronous, active-high):
  - prescaler = 0, counter = 3'b000, anode = 4'b1111, data_out = 8'h00, frame_tick = 0.
  - All outputs are registered; reset forces them immediately, mid-operation included.
- Prescaler:
  - When enable=1, it counts 0..DIV-1 and wraps to 0.
  - tick = (enable && prescaler == DIV-1).
  - When enable=0, the prescaler holds its value.
- Phase counter:
  - On tick, counter <= counter+1 mod 8 (111 wraps to 000). Otherwise it holds.
  - Each phase lasts exactly DIV cycles while enable stays high.
- Anode:
  - Registered, and decoded from the next counter value, so it changes on the same edge as counter.
  - Next counter 001: anode[HI_DIGIT]=0, all other bits 1.
  - Next counter 101: anode[LO_DIGIT]=0, all other bits 1.
  - Every other phase (x00 guard, x10 guard, x11 blank): anode = 4'b1111.
  - Guard phases absorb the character generator's one-cycle register latency, so no ghosting occurs.
- Enable low:
  - The next edge forces anode = 4'b1111. counter, prescaler and data_out hold.
  - Re-enable: scanning resumes from the held prescaler and counter values, and anode is re-decoded from the current counter on the first enabled edge.
- Snapshot:
  - On the tick where counter goes 111→000, data_out <= data_in and frame_tick = 1 for that single cycle.
  - At all other times frame_tick = 0 and data_out holds.
  - data_in changes mid-frame never reach data_out within the current frame.
- Simultaneous events:
  - Reset dominates everything.
  - enable falling on the same edge as a would-be tick: no tick occurs (the tick is gated by enable).
- Frame period: 8·DIV cycles.

Test Plan:
- DIV=4, reset pulse, then enable=1 → counter=000 and anode=1111 for 4 cycles; at edge 4, counter=001 and anode=4'b1101; at edge 8, counter=010 and anode=1111.
- DIV=4, run a full frame → counter sequence 000..111 at 4 cycles each; anode=4'b1110 only during phase 101; frame_tick pulses exactly once at edge 32 with counter=000.
- data_in=8'hA5 before the wrap, then changed to 8'h3C at counter=010 → data_out=A5 after the first wrap and stays A5 until the next wrap, then becomes 3C.
- enable=0 during phase 001 with prescaler=2 → next edge anode=1111; counter=001 and prescaler=2 hold for 10 cycles. Re-enable → anode=1101 on the first enabled edge; counter=010 two cycles later.
- Assert reset mid-phase 101 (asynchronous, between edges) → immediately counter=000, anode=1111, data_out=00, frame_tick=0; after release, timing matches test 1.
- DIV=2, HI_DIGIT=3, LO_DIGIT=2 → phase 001 gives anode=4'b0111, phase 101 gives 4'b1011; frame_tick period = 16 cycles.
